// File: rtl/decoder.sv
// rtl/decoder.sv - combinational RV32I decoder producing the datapath control bundle
// clk/reset exist only for top-level uniformity; nothing here is clocked.

module decoder (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] io_dec_instr,
   output logic        io_ctl_val_inst,
   output logic        io_ctl_rf_wen,
   output logic [3:0]  io_ctl_br_type,
   output logic [1:0]  io_ctl_opa_sel,
   output logic [1:0]  io_ctl_opb_sel,
   output logic [3:0]  io_ctl_alu_func,
   output logic [1:0]  io_ctl_wb_sel,
   output logic [1:0]  io_ctl_mem_func,
   output logic        io_ctl_mem_en,
   output logic [2:0]  io_ctl_msk_sel,
   output logic [2:0]  io_ctl_csr_cmd
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_MISC   = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
   localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_COPY_A = 4'd10;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = io_dec_instr[6:0];
   assign funct3 = io_dec_instr[14:12];
   assign funct7 = io_dec_instr[31:25];

   logic       val, wen, men;
   logic [3:0] br, alu;
   logic [1:0] opa, opb, wb, mf;
   logic [2:0] msk, csr;

   // Shared by OP and OP-IMM; alt selects SUB/SRA (funct7 bit 5).
   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   always_comb begin
      val = 1'b0; wen = 1'b0; br = 4'd0; opa = 2'd0; opb = 2'd0; alu = ALU_ADD;
      wb = 2'd0; mf = 2'd0; men = 1'b0; msk = 3'd0; csr = 3'd0;
      case (opcode)
         OPC_LUI:   begin val = 1'b1; wen = 1'b1; opa = 2'd3; opb = 2'd3; end
         OPC_AUIPC: begin val = 1'b1; wen = 1'b1; opa = 2'd1; opb = 2'd3; end
         OPC_JAL:   begin val = 1'b1; wen = 1'b1; br = 4'd7; wb = 2'd2; end
         OPC_JALR: begin
            val = (funct3 == 3'b000); wen = 1'b1; br = 4'd8; opb = 2'd1; wb = 2'd2;
         end
         OPC_BRANCH: begin
            val = 1'b1;
            case (funct3)
               3'b000:  br = 4'd2;
               3'b001:  br = 4'd1;
               3'b100:  br = 4'd5;
               3'b101:  br = 4'd3;
               3'b110:  br = 4'd6;
               3'b111:  br = 4'd4;
               default: val = 1'b0;
            endcase
         end
         // Mask codes line up with funct3 + 1 for both loads and stores.
         OPC_LOAD: begin
            val = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
            wen = 1'b1; opb = 2'd1; wb = 2'd1; men = 1'b1; mf = 2'd1; msk = funct3 + 3'd1;
         end
         OPC_STORE: begin
            val = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
            opb = 2'd2; men = 1'b1; mf = 2'd2; msk = funct3 + 3'd1;
         end
         OPC_OPIMM: begin
            wen = 1'b1; opb = 2'd1;
            alu = alu_from_f3(funct3, funct7[5] && funct3 == 3'b101);
            case (funct3)
               3'b001:  val = (funct7 == 7'h00);
               3'b101:  val = (funct7 == 7'h00) || (funct7 == 7'h20);
               default: val = 1'b1;
            endcase
         end
         OPC_OP: begin
            wen = 1'b1;
            alu = alu_from_f3(funct3, funct7[5]);
            val = (funct7 == 7'h00) ||
                  (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
         end
         OPC_MISC: val = (funct3[2:1] == 2'b00);
         OPC_SYSTEM: begin
            if (funct3 == 3'b000) begin
               case (io_dec_instr)
                  32'h0000_0073, 32'h0010_0073, 32'h3020_0073: begin val = 1'b1; csr = 3'd4; end
                  32'h1050_0073: val = 1'b1;
                  default:       val = 1'b0;
               endcase
            end else begin
               val = (funct3 != 3'b100);
               wen = 1'b1; alu = ALU_COPY_A; wb = 2'd3;
               opa = funct3[2] ? 2'd2 : 2'd0;
               csr = {1'b0, funct3[1:0]};
            end
         end
         default: val = 1'b0;
      endcase
   end

   // Illegal encodings force the whole bundle to zero.
   assign io_ctl_val_inst = val;
   assign io_ctl_rf_wen   = val & wen;
   assign io_ctl_br_type  = val ? br  : 4'd0;
   assign io_ctl_opa_sel  = val ? opa : 2'd0;
   assign io_ctl_opb_sel  = val ? opb : 2'd0;
   assign io_ctl_alu_func = val ? alu : 4'd0;
   assign io_ctl_wb_sel   = val ? wb  : 2'd0;
   assign io_ctl_mem_func = val ? mf  : 2'd0;
   assign io_ctl_mem_en   = val & men;
   assign io_ctl_msk_sel  = val ? msk : 3'd0;
   assign io_ctl_csr_cmd  = val ? csr : 3'd0;

   logic unused_clk_reset;
   assign unused_clk_reset = ^{clk, reset};

endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - randomized decoder check against a mask/match rule table
// Reference is a first-match table of (mask, match, control bundle) rules.

module tb_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        val, wen, men;
   logic [3:0]  br, alu;
   logic [1:0]  opa, opb, wb, mf;
   logic [2:0]  msk, csr;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   decoder dut (
      .clk(clk), .reset(reset), .io_dec_instr(instr),
      .io_ctl_val_inst(val), .io_ctl_rf_wen(wen), .io_ctl_br_type(br),
      .io_ctl_opa_sel(opa), .io_ctl_opb_sel(opb), .io_ctl_alu_func(alu),
      .io_ctl_wb_sel(wb), .io_ctl_mem_func(mf), .io_ctl_mem_en(men),
      .io_ctl_msk_sel(msk), .io_ctl_csr_cmd(csr)
   );

   // Bundle: val wen br[4] opa[2] opb[2] alu[4] wb[2] mf[2] men msk[3] csr[3] = 25 bits
   function automatic logic [24:0] mk(input int v, w, b, a, o, f, s, m, e, k, c);
      return {v[0], w[0], b[3:0], a[1:0], o[1:0], f[3:0], s[1:0], m[1:0], e[0], k[2:0], c[2:0]};
   endfunction

   logic [24:0] got;
   assign got = {val, wen, br, opa, opb, alu, wb, mf, men, msk, csr};

   logic [31:0] rule_mask[$];
   logic [31:0] rule_match[$];
   logic [24:0] rule_ctl[$];

   function automatic void add_rule(input logic [31:0] m, input logic [31:0] p, input logic [24:0] c);
      rule_mask.push_back(m);
      rule_match.push_back(p);
      rule_ctl.push_back(c);
   endfunction

   function automatic logic [24:0] ref_decode(input logic [31:0] ins);
      for (int i = 0; i < rule_mask.size(); i++)
         if ((ins & rule_mask[i]) == rule_match[i]) return rule_ctl[i];
      return 25'd0;
   endfunction

   task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s instr=%08h got=%07h exp=%07h", tag, instr, obs, exp);
      end
   endtask

   task automatic apply(input logic [31:0] w);
      @(posedge clk);
      instr = w;
      #2;
   endtask

   function automatic void build_rules();
      logic [31:0] f3m = 32'h0000_707F;
      logic [31:0] rm  = 32'hFE00_707F;
      add_rule(32'h7F, 32'h37, mk(1,1,0,3,3,0,0,0,0,0,0));
      add_rule(32'h7F, 32'h17, mk(1,1,0,1,3,0,0,0,0,0,0));
      add_rule(32'h7F, 32'h6F, mk(1,1,7,0,0,0,2,0,0,0,0));
      add_rule(f3m, 32'h67, mk(1,1,8,0,1,0,2,0,0,0,0));
      add_rule(f3m, 32'h0063, mk(1,0,2,0,0,0,0,0,0,0,0));
      add_rule(f3m, 32'h1063, mk(1,0,1,0,0,0,0,0,0,0,0));
      add_rule(f3m, 32'h4063, mk(1,0,5,0,0,0,0,0,0,0,0));
      add_rule(f3m, 32'h5063, mk(1,0,3,0,0,0,0,0,0,0,0));
      add_rule(f3m, 32'h6063, mk(1,0,6,0,0,0,0,0,0,0,0));
      add_rule(f3m, 32'h7063, mk(1,0,4,0,0,0,0,0,0,0,0));
      add_rule(f3m, 32'h0003, mk(1,1,0,0,1,0,1,1,1,1,0));
      add_rule(f3m, 32'h1003, mk(1,1,0,0,1,0,1,1,1,2,0));
      add_rule(f3m, 32'h2003, mk(1,1,0,0,1,0,1,1,1,3,0));
      add_rule(f3m, 32'h4003, mk(1,1,0,0,1,0,1,1,1,5,0));
      add_rule(f3m, 32'h5003, mk(1,1,0,0,1,0,1,1,1,6,0));
      add_rule(f3m, 32'h0023, mk(1,0,0,0,2,0,0,2,1,1,0));
      add_rule(f3m, 32'h1023, mk(1,0,0,0,2,0,0,2,1,2,0));
      add_rule(f3m, 32'h2023, mk(1,0,0,0,2,0,0,2,1,3,0));
      add_rule(f3m, 32'h0013, mk(1,1,0,0,1,0,0,0,0,0,0));
      add_rule(f3m, 32'h2013, mk(1,1,0,0,1,3,0,0,0,0,0));
      add_rule(f3m, 32'h3013, mk(1,1,0,0,1,4,0,0,0,0,0));
      add_rule(f3m, 32'h4013, mk(1,1,0,0,1,5,0,0,0,0,0));
      add_rule(f3m, 32'h6013, mk(1,1,0,0,1,8,0,0,0,0,0));
      add_rule(f3m, 32'h7013, mk(1,1,0,0,1,9,0,0,0,0,0));
      add_rule(rm, 32'h0000_1013, mk(1,1,0,0,1,2,0,0,0,0,0));
      add_rule(rm, 32'h0000_5013, mk(1,1,0,0,1,6,0,0,0,0,0));
      add_rule(rm, 32'h4000_5013, mk(1,1,0,0,1,7,0,0,0,0,0));
      add_rule(rm, 32'h0000_0033, mk(1,1,0,0,0,0,0,0,0,0,0));
      add_rule(rm, 32'h4000_0033, mk(1,1,0,0,0,1,0,0,0,0,0));
      add_rule(rm, 32'h0000_1033, mk(1,1,0,0,0,2,0,0,0,0,0));
      add_rule(rm, 32'h0000_2033, mk(1,1,0,0,0,3,0,0,0,0,0));
      add_rule(rm, 32'h0000_3033, mk(1,1,0,0,0,4,0,0,0,0,0));
      add_rule(rm, 32'h0000_4033, mk(1,1,0,0,0,5,0,0,0,0,0));
      add_rule(rm, 32'h0000_5033, mk(1,1,0,0,0,6,0,0,0,0,0));
      add_rule(rm, 32'h4000_5033, mk(1,1,0,0,0,7,0,0,0,0,0));
      add_rule(rm, 32'h0000_6033, mk(1,1,0,0,0,8,0,0,0,0,0));
      add_rule(rm, 32'h0000_7033, mk(1,1,0,0,0,9,0,0,0,0,0));
      add_rule(f3m, 32'h000F, mk(1,0,0,0,0,0,0,0,0,0,0));
      add_rule(f3m, 32'h100F, mk(1,0,0,0,0,0,0,0,0,0,0));
      add_rule(f3m, 32'h1073, mk(1,1,0,0,0,10,3,0,0,0,1));
      add_rule(f3m, 32'h2073, mk(1,1,0,0,0,10,3,0,0,0,2));
      add_rule(f3m, 32'h3073, mk(1,1,0,0,0,10,3,0,0,0,3));
      add_rule(f3m, 32'h5073, mk(1,1,0,2,0,10,3,0,0,0,1));
      add_rule(f3m, 32'h6073, mk(1,1,0,2,0,10,3,0,0,0,2));
      add_rule(f3m, 32'h7073, mk(1,1,0,2,0,10,3,0,0,0,3));
      add_rule(32'hFFFF_FFFF, 32'h0000_0073, mk(1,0,0,0,0,0,0,0,0,0,4));
      add_rule(32'hFFFF_FFFF, 32'h0010_0073, mk(1,0,0,0,0,0,0,0,0,0,4));
      add_rule(32'hFFFF_FFFF, 32'h3020_0073, mk(1,0,0,0,0,0,0,0,0,0,4));
      add_rule(32'hFFFF_FFFF, 32'h1050_0073, mk(1,0,0,0,0,0,0,0,0,0,0));
   endfunction

   logic [6:0]  opcs[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
   logic [31:0] sysw[6]  = '{32'h0000_0073, 32'h0010_0073, 32'h3020_0073, 32'h1050_0073,
                             32'h0020_0073, 32'h1050_00F3};

   initial begin
      logic [31:0] r;
      logic [24:0] held;
      build_rules();

      apply(32'h0050_0093); check("addi",   got, mk(1,1,0,0,1,0,0,0,0,0,0));
      apply(32'h4020_80B3); check("sub",    got, mk(1,1,0,0,0,1,0,0,0,0,0));
      apply(32'h0220_80B3); check("sub_f7", got, 25'd0);
      apply(32'h0020_A223); check("sw",     got, mk(1,0,0,0,2,0,0,2,1,3,0));
      apply(32'h0000_C083); check("lbu",    got, mk(1,1,0,0,1,0,1,1,1,5,0));
      apply(32'h0020_8463); check("beq",    got, mk(1,0,2,0,0,0,0,0,0,0,0));
      apply(32'h0000_00EF); check("jal",    got, mk(1,1,7,0,0,0,2,0,0,0,0));
      apply(32'h3001_10F3); check("csrrw",  got, mk(1,1,0,0,0,10,3,0,0,0,1));
      apply(32'h0000_0073); check("ecall",  got, mk(1,0,0,0,0,0,0,0,0,0,4));
      apply(32'h0000_0000); check("zero",   got, 25'd0);
      apply(32'hFFFF_FFFF); check("ones",   got, 25'd0);
      apply(32'h0020_A463); check("blt_f3_010", got, 25'd0);
      apply(32'h4000_1013); check("slli_f7", got, 25'd0);

      // Reset must not disturb the decoded bundle.
      apply(32'h3001_10F3);
      held = ref_decode(instr);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #2 check("reset_hold", got, held);
      reset = 1'b0;
      @(posedge clk);
      #2 check("reset_rel", got, held);

      for (int i = 0; i < 3000; i++) begin
         int sel;
         r = $urandom;
         sel = $urandom_range(0, 15);
         if (sel < 11) r[6:0] = opcs[sel];
         else if (sel == 11) r = sysw[$urandom_range(0, 5)];
         case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
         endcase
         reset = ($urandom_range(0, 7) == 0);
         apply(r);
         check("rand", got, ref_decode(r));
      end
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
